// File: rtl/hpdcache_mem_write_flit_packer_pkg.sv
// hpdcache_mem_write_flit_packer_pkg: memory write request/data types and flit packer enums.
package hpdcache_mem_write_flit_packer_pkg;

    typedef struct packed {
        logic [31:0] mem_req_addr;
        logic [7:0]  mem_req_len;
        logic [3:0]  mem_req_id;
    } hpdcache_mem_req_t;

    typedef struct packed {
        logic [31:0] mem_req_w_data;
        logic [3:0]  mem_req_w_be;
        logic        mem_req_w_last;
    } hpdcache_mem_req_w_t;

    localparam int unsigned HPDCACHE_MEM_REQ_W   = $bits(hpdcache_mem_req_t);
    localparam int unsigned HPDCACHE_MEM_REQ_W_W = $bits(hpdcache_mem_req_w_t);
    localparam int unsigned HPDCACHE_FLIT_W      = (HPDCACHE_MEM_REQ_W > HPDCACHE_MEM_REQ_W_W) ?
                                                   HPDCACHE_MEM_REQ_W : HPDCACHE_MEM_REQ_W_W;

    typedef enum logic [1:0] {
        HEAD = 2'd0,
        BODY = 2'd1,
        TAIL = 2'd2
    } hpdcache_flit_kind_e;

    typedef enum logic {
        IDLE = 1'b0,
        DATA = 1'b1
    } hpdcache_flit_fsm_e;

    function automatic logic [7:0] req_len(input hpdcache_mem_req_t r);
        return r.mem_req_len;
    endfunction

    function automatic logic w_last(input hpdcache_mem_req_w_t w);
        return w.mem_req_w_last;
    endfunction

endpackage

// File: rtl/hpdcache_fifo_reg.sv
// hpdcache_fifo_reg: small register FIFO; a write is accepted when full if a read drains the same cycle.
module hpdcache_fifo_reg
    import hpdcache_mem_write_flit_packer_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 1,
    parameter bit          FEEDTHROUGH = 1'b0,
    parameter type         fifo_data_t = logic
)(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       w_i,
    output logic       wok_o,
    input  fifo_data_t wdata_i,
    input  logic       r_i,
    output logic       rok_o,
    output fifo_data_t rdata_o
);
    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    fifo_data_t    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wptr_q, rptr_q;
    logic [PW:0]   cnt_q;
    logic          empty, full, ft, do_r, do_w, push, pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == (PW+1)'(FIFO_DEPTH));
    assign ft      = FEEDTHROUGH && empty;
    assign wok_o   = !full;
    assign rok_o   = ft ? w_i : !empty;
    assign rdata_o = ft ? wdata_i : mem_q[rptr_q];
    assign do_r    = r_i & rok_o;
    assign do_w    = w_i & (!full | r_i);
    assign push    = do_w & !(ft & do_r);
    assign pop     = do_r & !ft;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wptr_q] <= wdata_i;
                wptr_q        <= nxt(wptr_q);
            end
            if (pop) rptr_q <= nxt(rptr_q);
            cnt_q <= cnt_q + (PW+1)'(push) - (PW+1)'(pop);
        end
    end
endmodule

// File: rtl/hpdcache_mem_write_flit_packer.sv
// hpdcache_mem_write_flit_packer: serializes a write request and its data beats into HEAD/BODY/TAIL flits.
module hpdcache_mem_write_flit_packer
    import hpdcache_mem_write_flit_packer_pkg::*;
#(
    parameter int unsigned FLIT_W = HPDCACHE_FLIT_W
)(
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            req_valid_i,
    output logic                            req_ready_o,
    input  logic [HPDCACHE_MEM_REQ_W-1:0]   req_i,
    input  logic                            data_valid_i,
    output logic                            data_ready_o,
    input  logic [HPDCACHE_MEM_REQ_W_W-1:0] data_i,
    output logic                            flit_valid_o,
    input  logic                            flit_ready_i,
    output logic [1:0]                      flit_kind_o,
    output logic [FLIT_W-1:0]               flit_o,
    output logic                            err_len_o,
    output logic                            busy_o
);
    hpdcache_flit_fsm_e state_q;
    logic [8:0]         cnt_q, exp_q;
    logic               err_q;
    logic               slot_wok, slot_w, slot_free, req_hs, data_hs, data_last;
    logic [FLIT_W+1:0]  slot_wdata, slot_rdata;

    assign slot_free    = slot_wok | flit_ready_i;
    assign req_ready_o  = (state_q == IDLE) & slot_free;
    assign data_ready_o = (state_q == DATA) & slot_free;
    assign req_hs       = req_valid_i & req_ready_o;
    assign data_hs      = data_valid_i & data_ready_o;
    assign data_last    = w_last(data_i);
    assign slot_w       = req_hs | data_hs;
    assign slot_wdata   = req_hs ? {HEAD, FLIT_W'(req_i)} : {data_last ? TAIL : BODY, FLIT_W'(data_i)};
    assign flit_kind_o  = slot_rdata[FLIT_W+1:FLIT_W];
    assign flit_o       = slot_rdata[FLIT_W-1:0];
    assign err_len_o    = err_q;
    assign busy_o       = (state_q != IDLE) | flit_valid_o;

    // Overrun is flagged at the first extra beat only; a short packet is flagged at its tail.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            exp_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= data_hs & ((cnt_q == exp_q) | (data_last & (cnt_q < exp_q - 9'd1)));
            if (req_hs) begin
                state_q <= DATA;
                exp_q   <= {1'b0, req_len(req_i)} + 9'd1;
                cnt_q   <= '0;
            end
            if (data_hs) begin
                cnt_q <= (cnt_q == 9'd511) ? cnt_q : cnt_q + 9'd1;
                if (data_last) state_q <= IDLE;
            end
        end
    end

    hpdcache_fifo_reg #(
        .FIFO_DEPTH  (1),
        .FEEDTHROUGH (1'b0),
        .fifo_data_t (logic [FLIT_W+1:0])
    ) i_slot (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .w_i     (slot_w),
        .wok_o   (slot_wok),
        .wdata_i (slot_wdata),
        .r_i     (flit_ready_i),
        .rok_o   (flit_valid_o),
        .rdata_o (slot_rdata)
    );
endmodule

// File: tb/tb_hpdcache_mem_write_flit_packer.sv
// tb_hpdcache_mem_write_flit_packer: directed and randomized packets checked against a flit-stream model.
module tb_hpdcache_mem_write_flit_packer;
    import hpdcache_mem_write_flit_packer_pkg::*;

    localparam int FW = HPDCACHE_FLIT_W;

    logic                            clk = 1'b0;
    logic                            rst;
    logic                            req_valid_i = 1'b0, req_ready_o;
    logic [HPDCACHE_MEM_REQ_W-1:0]   req_i = '0;
    logic                            data_valid_i = 1'b0, data_ready_o;
    logic [HPDCACHE_MEM_REQ_W_W-1:0] data_i = '0;
    logic                            flit_valid_o, flit_ready_i;
    logic [1:0]                      flit_kind_o;
    logic [FW-1:0]                   flit_o;
    logic                            err_len_o, busy_o;

    always #5 clk = ~clk;

    hpdcache_mem_write_flit_packer dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_i        (req_i),
        .data_valid_i (data_valid_i),
        .data_ready_o (data_ready_o),
        .data_i       (data_i),
        .flit_valid_o (flit_valid_o),
        .flit_ready_i (flit_ready_i),
        .flit_kind_o  (flit_kind_o),
        .flit_o       (flit_o),
        .err_len_o    (err_len_o),
        .busy_o       (busy_o)
    );

    int checks = 0, errors = 0;
    int cyc = 0, mode = 1, exp_errs = 0;
    logic chk_stream = 1'b1;
    logic stall_pend = 1'b0;
    logic [FW+1:0] stall_val;
    logic [FW+1:0] exp_flits[$];
    int flit_cyc[$], err_cyc[$], dh_cyc[$], rh_cyc[$];
    hpdcache_mem_req_t   reqs[$];
    hpdcache_mem_req_w_t beats[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (mode == 0) flit_ready_i = 1'($urandom_range(0, 1));
        else if (mode == 2) flit_ready_i = ~flit_ready_i;
        else flit_ready_i = 1'b1;
    end

    // Observes handshakes between edges; stalled flits must not change.
    always @(negedge clk) begin
        if (rst) stall_pend = 1'b0;
        else begin
            if (stall_pend) check("stall_hold", {flit_valid_o, flit_kind_o, flit_o}, {1'b1, stall_val});
            stall_pend = flit_valid_o & !flit_ready_i;
            stall_val  = {flit_kind_o, flit_o};
            if (flit_valid_o & flit_ready_i) begin
                flit_cyc.push_back(cyc);
                if (chk_stream) begin
                    if (exp_flits.size() == 0) check("flit_extra", 64'(flit_kind_o), 64'd3);
                    else check("flit", {flit_kind_o, flit_o}, exp_flits.pop_front());
                end
            end
            if (err_len_o) err_cyc.push_back(cyc);
            if (data_valid_i & data_ready_o) dh_cyc.push_back(cyc);
            if (req_valid_i & req_ready_o) rh_cyc.push_back(cyc);
        end
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_req(input hpdcache_mem_req_t r);
        int n = 0;
        req_valid_i = 1'b1;
        req_i = r;
        @(negedge clk);
        while (!req_ready_o && n < 300) begin @(negedge clk); n++; end
        if (n >= 300) check("req_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        req_valid_i = 1'b0;
    endtask

    task automatic send_beat(input hpdcache_mem_req_w_t w);
        int n = 0;
        data_valid_i = 1'b1;
        data_i = w;
        @(negedge clk);
        while (!data_ready_o && n < 300) begin @(negedge clk); n++; end
        if (n >= 300) check("data_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        data_valid_i = 1'b0;
    endtask

    // Packet of length field len carrying nb data beats, last flagged on beat nb.
    task automatic add_pkt(input int len, input int nb, input int id);
        hpdcache_mem_req_t   r;
        hpdcache_mem_req_w_t w;
        logic [FW-1:0]       p;
        r.mem_req_addr = $urandom;
        r.mem_req_len  = 8'(len);
        r.mem_req_id   = 4'(id);
        reqs.push_back(r);
        p = '0;
        p[HPDCACHE_MEM_REQ_W-1:0] = r;
        exp_flits.push_back({HEAD, p});
        for (int b = 1; b <= nb; b++) begin
            w.mem_req_w_data = $urandom;
            w.mem_req_w_be   = 4'($urandom);
            w.mem_req_w_last = (b == nb);
            beats.push_back(w);
            p = '0;
            p[HPDCACHE_MEM_REQ_W_W-1:0] = w;
            exp_flits.push_back({(b == nb) ? TAIL : BODY, p});
        end
        if (nb != len + 1) exp_errs++;
    endtask

    task automatic run_batch(input int gmax, input int rdly);
        int n = 0;
        flit_cyc.delete(); err_cyc.delete(); dh_cyc.delete(); rh_cyc.delete();
        fork
            begin
                repeat (rdly) begin @(negedge clk); check("early_data_ready", 64'(data_ready_o), 64'd0); end
                if (rdly > 0) begin @(posedge clk); #1; end
                foreach (reqs[i]) begin idle($urandom_range(0, gmax)); send_req(reqs[i]); end
            end
            begin
                foreach (beats[i]) begin idle($urandom_range(0, gmax)); send_beat(beats[i]); end
            end
        join
        reqs.delete();
        beats.delete();
        while (exp_flits.size() != 0 && n < 600) begin @(negedge clk); n++; end
        check("drain_left", 64'(exp_flits.size()), 64'd0);
        repeat (3) @(negedge clk);
        check("err_pulses", 64'(err_cyc.size()), 64'(exp_errs));
        check("busy_idle", 64'(busy_o), 64'd0);
        exp_errs = 0;
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1;
        flit_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_flit_valid", 64'(flit_valid_o), 64'd0);
        check("rst_flit_kind", 64'(flit_kind_o), 64'd0);
        check("rst_flit", 64'(flit_o), 64'd0);
        check("rst_err", 64'(err_len_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_req_ready", 64'(req_ready_o), 64'd1);
        check("rst_data_ready", 64'(data_ready_o), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(2);

        mode = 1;
        add_pkt(0, 1, 5);
        run_batch(0, 0);
        check("single_head_lat", 64'(flit_cyc[0]), 64'(rh_cyc[0] + 1));
        check("single_tail_next", 64'(flit_cyc[1]), 64'(flit_cyc[0] + 1));

        mode = 2;
        add_pkt(3, 4, 2);
        run_batch(0, 0);
        check("burst_flits", 64'(flit_cyc.size()), 64'd5);

        mode = 1;
        add_pkt(1, 2, 7);
        run_batch(0, 3);
        check("early_first_beat", 64'(dh_cyc[0]), 64'(rh_cyc[0] + 1));

        add_pkt(3, 2, 1);
        run_batch(0, 0);
        check("short_err_cycle", 64'(err_cyc[0]), 64'(dh_cyc[1] + 1));

        add_pkt(1, 4, 3);
        run_batch(0, 0);
        check("long_err_cycle", 64'(err_cyc[0]), 64'(dh_cyc[2] + 1));

        add_pkt(1, 2, 4);
        add_pkt(0, 1, 6);
        run_batch(0, 0);
        check("tput_count", 64'(flit_cyc.size()), 64'd5);
        check("tput_span", 64'(flit_cyc[4] - flit_cyc[0]), 64'd4);

        chk_stream = 1'b0;
        begin
            hpdcache_mem_req_t   r;
            hpdcache_mem_req_w_t w;
            r = '0; r.mem_req_len = 8'd3; r.mem_req_id = 4'd9;
            w = '0; w.mem_req_w_data = 32'hdead_beef;
            fork
                send_req(r);
                send_beat(w);
            join
        end
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 64'(flit_valid_o), 64'd0);
        check("mid_rst_flit", {flit_kind_o, flit_o}, 64'd0);
        check("mid_rst_err", 64'(err_len_o), 64'd0);
        check("mid_rst_busy", 64'(busy_o), 64'd0);
        check("mid_rst_rdys", {req_ready_o, data_ready_o}, 64'b10);
        @(posedge clk); #1;
        rst = 1'b0;
        chk_stream = 1'b1;
        idle(1);
        add_pkt(0, 1, 8);
        run_batch(0, 0);

        add_pkt(255, 256, 10);
        add_pkt(1, 520, 11);
        run_batch(0, 0);

        for (int b = 0; b < 20; b++) begin
            mode = (b % 4 == 3) ? 2 : 0;
            for (int k = 0; k < 3; k++) begin
                int len, nb;
                len = $urandom_range(0, 5);
                nb  = ($urandom_range(0, 9) < 7) ? len + 1 : $urandom_range(1, len + 4);
                add_pkt(len, nb, $urandom_range(0, 15));
            end
            run_batch(2, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
